// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared types and constants for the gate truth-table checker
package gate_tt_pkg;

  localparam int PAT_W   = 3;
  localparam int NUM_PAT = 8;
  localparam int CNT_W   = 4;

  // Reference truth table for a 3-input NAND: only pattern 7 (A=B=C=1) yields 0.
  localparam logic [NUM_PAT-1:0] NAND3_TT = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_e;

  // Expected gate output for one input pattern of a truth table.
  function automatic logic tt_lookup(input logic [NUM_PAT-1:0] tt,
                                     input logic [PAT_W-1:0]   pat);
    return tt[pat];
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - settle-window counter that flags when the limit is reached
module tt_settle_timer
  import gate_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // Counts cycles while not cleared; the checker holds clear outside the settle window.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == limit);

endmodule

// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - walks all 8 input patterns through a gate and scores its output
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [NUM_PAT-1:0] EXPECTED = NAND3_TT,
  parameter int                 SETTLE   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_y,
  output logic [PAT_W-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic             fail_valid,
  output logic [PAT_W-1:0] first_fail
);

  // The timer expires on the last settle cycle, i.e. after SETTLE cycles in ST_SETTLE.
  localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE - 1);
  localparam logic [PAT_W-1:0] LAST_PAT     = PAT_W'(NUM_PAT - 1);
  localparam logic [3:0]       ERR_MAX      = 4'(NUM_PAT);

  tt_state_e        state, state_n;
  logic [PAT_W-1:0] pattern_n;
  logic [3:0]       err_count_n;
  logic             fail_valid_n;
  logic [PAT_W-1:0] first_fail_n;
  logic             timer_clear;
  logic             timer_expire;
  logic             mismatch;

  tt_settle_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .limit  (SETTLE_LIMIT),
    .expire (timer_expire)
  );

  assign mismatch = (dut_y != tt_lookup(EXPECTED, pattern));

  // State and result registers; reset wipes any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pattern    <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      state      <= state_n;
      pattern    <= pattern_n;
      err_count  <= err_count_n;
      fail_valid <= fail_valid_n;
      first_fail <= first_fail_n;
    end
  end

  // Next-state and datapath updates; the timer only runs inside the settle window.
  always_comb begin
    state_n      = state;
    pattern_n    = pattern;
    err_count_n  = err_count;
    fail_valid_n = fail_valid;
    first_fail_n = first_fail;
    timer_clear  = 1'b1;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n      = ST_SETTLE;
          pattern_n    = '0;
          err_count_n  = '0;
          fail_valid_n = 1'b0;
          first_fail_n = '0;
        end
      end

      ST_SETTLE: begin
        timer_clear = 1'b0;
        if (timer_expire) begin
          state_n = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) begin
            err_count_n = err_count + 1'b1;
          end
          if (!fail_valid) begin
            fail_valid_n = 1'b1;
            first_fail_n = pattern;
          end
        end
        if (pattern == LAST_PAT) begin
          state_n = ST_DONE;
        end else begin
          pattern_n = pattern + 1'b1;
          state_n   = ST_SETTLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 4'd0);

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - scoreboard bench for gate_tt_checker
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       pass_v;
    logic [3:0] err;
    logic       fv;
    logic [2:0] ff;
    int         lat;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  exp_t e2, e1;
  int   start_edge2 = 0;
  int   start_edge1 = 0;

  // DUT with SETTLE=2 driven by a zero-delay gate model
  logic       rst, start, dut_y;
  logic [2:0] pattern, first_fail;
  logic       busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [1:0] mode;

  always_comb begin
    case (mode)
      2'd1:    dut_y = 1'b1;
      2'd2:    dut_y = 1'b0;
      default: dut_y = ~&pattern;
    endcase
  end

  gate_tt_checker #(.EXPECTED(8'h7F), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dut_y(dut_y),
    .pattern(pattern), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail(first_fail)
  );

  // DUT with SETTLE=1 driven by a NAND3 model with one or two cycles of delay
  logic       rst1, start1, dut_y1, two_delay;
  logic [2:0] pattern1, first_fail1;
  logic       busy1, done1, pass1, fail_valid1;
  logic [3:0] err_count1;
  logic       d1, d2;

  always @(posedge clk) begin
    d1 <= ~&pattern1;
    d2 <= d1;
  end
  assign dut_y1 = two_delay ? d2 : d1;

  gate_tt_checker #(.EXPECTED(8'h7F), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .dut_y(dut_y1),
    .pattern(pattern1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .fail_valid(fail_valid1), .first_fail(first_fail1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [3:0] err, input logic fv,
                              input logic [2:0] ff, input int lat);
    exp_t e;
    e.pass_v = p; e.err = err; e.fv = fv; e.ff = ff; e.lat = lat;
    return e;
  endfunction

  // Monitor for the SETTLE=2 instance: score each completed run against the queue head
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_done", done, 1'b0);
      end else begin
        e2 = q2.pop_front();
        check("dut2_pass", pass, e2.pass_v);
        check("dut2_err_count", err_count, e2.err);
        check("dut2_fail_valid", fail_valid, e2.fv);
        if (e2.fv) check("dut2_first_fail", first_fail, e2.ff);
        check("dut2_done_latency", cyc - start_edge2, e2.lat);
      end
    end
    done_q = done;
  end

  // Monitor for the SETTLE=1 instance
  logic done1_q = 1'b0;
  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", done1, 1'b0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_pass", pass1, e1.pass_v);
        check("dut1_err_count", err_count1, e1.err);
        check("dut1_fail_valid", fail_valid1, e1.fv);
        if (e1.fv) check("dut1_first_fail", first_fail1, e1.ff);
        check("dut1_done_latency", cyc - start_edge1, e1.lat);
      end
    end
    done1_q = done1;
  end

  task automatic check_reset2(input string tag);
    check({tag, "_pattern"}, pattern, 3'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_err_count"}, err_count, 4'd0);
    check({tag, "_fail_valid"}, fail_valid, 1'b0);
    check({tag, "_first_fail"}, first_fail, 3'd0);
  endtask

  // Pulse start on the SETTLE=2 instance; returns at the negedge after the start edge.
  task automatic run2(input exp_t e);
    @(negedge clk);
    start = 1'b1;
    start_edge2 = cyc + 1;
    q2.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run1(input exp_t e);
    @(negedge clk);
    start1 = 1'b1;
    start_edge1 = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done2(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; start = 1'b0; start1 = 1'b0;
    mode = 2'd0; two_delay = 1'b0;
    repeat (3) @(negedge clk);
    check_reset2("reset");
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    // Good NAND3: check pattern stepping and hold time, then results via scoreboard
    run2(mk(1'b1, 4'd0, 1'b0, 3'd0, 24));
    check("t1_pattern_e0", pattern, 3'd0);
    check("t1_busy_e0", busy, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_pattern_e2", pattern, 3'd0);
    @(negedge clk);
    check("t1_pattern_e3", pattern, 3'd1);
    wait_done2("t1");
    check("t1_pattern_final", pattern, 3'd7);
    check("t1_busy_final", busy, 1'b0);

    // Output stuck at 1: only pattern 7 mismatches
    mode = 2'd1;
    run2(mk(1'b0, 4'd1, 1'b1, 3'd7, 24));
    wait_done2("t2");

    // Output stuck at 0: patterns 0..6 mismatch
    mode = 2'd2;
    run2(mk(1'b0, 4'd7, 1'b1, 3'd0, 24));
    wait_done2("t3");

    // Second start at edge 10 while busy must be ignored
    mode = 2'd0;
    run2(mk(1'b1, 4'd0, 1'b0, 3'd0, 24));
    repeat (9) @(negedge clk);
    check("t4_busy_at_restart", busy, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done2("t4");

    // Reset at edge 12 of a failing run leaves nothing behind
    mode = 2'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset2("t5_midrun_rst");
    mode = 2'd0;
    run2(mk(1'b1, 4'd0, 1'b0, 3'd0, 24));
    wait_done2("t5");

    // start and rst together resolve to reset
    @(negedge clk);
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check_reset2("t6_start_rst");

    // SETTLE=1, one-cycle-delay gate: every sample lands on the settled value
    two_delay = 1'b0;
    run1(mk(1'b1, 4'd0, 1'b0, 3'd0, 16));
    wait_done1("t7");

    // SETTLE=1, two-cycle-delay gate: samples see the previous pattern's output.
    // The prior pattern is 7 (NAND=0), so pattern 0 and pattern 7 both mismatch.
    two_delay = 1'b1;
    run1(mk(1'b0, 4'd2, 1'b1, 3'd0, 16));
    wait_done1("t8");

    @(negedge clk);
    check("q2_drained", q2.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 Parameter EXPECTED, default 8'h7F, SHALL give the expected output per input pattern; bit i is the value for pattern i = {A,B,C}. The default is the 3-input NAND truth table.
REQ-002 Parameter SETTLE, default 2, legal range 1..15, SHALL be the number of clk cycles the block waits after driving a pattern before it samples.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to run a full 8-pattern check.
REQ-006 dut_y  input  1  output of the gate under test.
REQ-007 pattern  output  3  drives the gate inputs; bit2=A, bit1=B, bit0=C.
REQ-008 busy  output  1  high while a check is in progress.
REQ-009 done  output  1  high from completion until the next start or rst.
REQ-010 pass  output  1  valid when done is high; 1 iff err_count==0.
REQ-011 err_count  output  4  number of mismatching patterns, 0..8.
REQ-012 fail_valid  output  1  set once at least one mismatch is recorded.
REQ-013 first_fail  output  3  the lowest pattern that mismatched; valid only when fail_valid is high.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-015 In IDLE or DONE, start=1 SHALL clear err_count, fail_valid and first_fail, set pattern=0 and the settle counter to 0, clear done, and move to SETTLE.
REQ-016 In SETTLE, the settle counter SHALL increment each cycle; when the counter equals SETTLE-1, the next state SHALL be SAMPLE.
REQ-017 In SAMPLE, the block SHALL compare dut_y with EXPECTED[pattern].
REQ-018 On a SAMPLE mismatch, err_count SHALL increment.
REQ-019 On the first SAMPLE mismatch, fail_valid SHALL be set and first_fail SHALL take the current pattern.
REQ-020 From SAMPLE with pattern<7, the block SHALL increment pattern, clear the settle counter and return to SETTLE.
REQ-021 From SAMPLE with pattern==7, the block SHALL go to DONE, keep pattern at 7, and set done.
REQ-022 Each pattern SHALL take SETTLE+1 cycles. With start sampled at edge 0, done SHALL first be high after edge 8*(SETTLE+1); with SETTLE=2, that is edge 24.
REQ-023 busy SHALL be high exactly in the SETTLE and SAMPLE states.
REQ-024 pattern SHALL change only on the SAMPLE-to-SETTLE transition or on start, so it is stable for the whole settle window.
REQ-025 start SHALL be ignored while busy is high; an in-progress run SHALL NOT be restarted.
REQ-026 err_count SHALL never exceed 8; no wrap is possible.
REQ-027 pass SHALL be 0 whenever done is 0.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=IDLE, pattern=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, and clear the settle counter.
REQ-029 rst SHALL take priority over start and over any state, including rst asserted in the middle of a run; the aborted run SHALL leave no residual results.
REQ-030 If start and rst are both high on the same edge, the result SHALL be the reset state.

Structure
REQ-031 A shared package gate_tt_pkg SHALL hold:
- the state enum
- PAT_W=3
- NUM_PAT=8
- the constant NAND3_TT=8'h7F
REQ-032 The settle counter SHALL be one sub-module, tt_settle_timer, with inputs clk, rst, clear and limit, and output expire.

Verification
REQ-033 Correct NAND3 model, SETTLE=2, start pulse -> pattern steps 0..7, each held 3 cycles; done at cycle 24; pass=1, err_count=0, fail_valid=0.
REQ-034 dut_y stuck at 1 -> err_count=1, first_fail=3'b111, fail_valid=1, pass=0.
REQ-035 dut_y stuck at 0 -> err_count=7, first_fail=3'b000, pass=0.
REQ-036 Pulse start again while busy at cycle 10 -> no restart; done still at cycle 24.
REQ-037 Assert rst at cycle 12 mid-run, then start -> all outputs at reset values after the rst edge; the new run completes cleanly with pass=1.
REQ-038 SETTLE=1 with a NAND3 model whose output has a one-cycle delay -> all 8 samples match and pass=1; the same model with SETTLE=1 and a two-cycle delay -> mismatches reported, pass=0.
